// File: rtl/nec_ir_receiver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nec_ir_receiver_if                                              |
// | Brief    : Decoded-key bundle from the NEC IR receiver to its consumers.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface nec_ir_receiver_if;
   logic [7:0] ir_button;
   logic [7:0] ir_addr;
   logic       code_valid;
   logic       repeat_valid;
   logic       frame_err;
   logic       busy;

   modport master (
      output ir_button, ir_addr, code_valid, repeat_valid, frame_err, busy
   );

   modport slave (
      input ir_button, ir_addr, code_valid, repeat_valid, frame_err, busy
   );
endinterface
`default_nettype wire

// File: rtl/nec_ir_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nec_ir_receiver                                                 |
// | Brief    : NEC IR frame decoder with repeat handling and key-hold timeout. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module nec_ir_receiver #(
   parameter int unsigned LEAD_MARK_CYC  = 450000,
   parameter int unsigned LEAD_SPACE_CYC = 225000,
   parameter int unsigned RPT_SPACE_CYC  = 112500,
   parameter int unsigned BIT_MARK_CYC   = 28125,
   parameter int unsigned ZERO_SPACE_CYC = 28125,
   parameter int unsigned ONE_SPACE_CYC  = 84375,
   parameter int unsigned HOLD_CYC       = 6000000,
   parameter logic [7:0]  IDLE_CODE      = 8'hFF,
   parameter bit          CHECK_ADDR     = 1'b0
) (
   input  wire               clk_50,
   input  wire               reset,
   input  wire               irda_rxd,
   nec_ir_receiver_if.master ir
);

   localparam int c_dur_w = 20;
   localparam logic [c_dur_w-1:0] c_dur_max = '1;

   localparam logic [31:0] c_lm_lo = LEAD_MARK_CYC  - LEAD_MARK_CYC  / 4;
   localparam logic [31:0] c_lm_hi = LEAD_MARK_CYC  + LEAD_MARK_CYC  / 4;
   localparam logic [31:0] c_ls_lo = LEAD_SPACE_CYC - LEAD_SPACE_CYC / 4;
   localparam logic [31:0] c_ls_hi = LEAD_SPACE_CYC + LEAD_SPACE_CYC / 4;
   localparam logic [31:0] c_rs_lo = RPT_SPACE_CYC  - RPT_SPACE_CYC  / 4;
   localparam logic [31:0] c_rs_hi = RPT_SPACE_CYC  + RPT_SPACE_CYC  / 4;
   localparam logic [31:0] c_bm_lo = BIT_MARK_CYC   - BIT_MARK_CYC   / 4;
   localparam logic [31:0] c_bm_hi = BIT_MARK_CYC   + BIT_MARK_CYC   / 4;
   localparam logic [31:0] c_zs_lo = ZERO_SPACE_CYC - ZERO_SPACE_CYC / 4;
   localparam logic [31:0] c_zs_hi = ZERO_SPACE_CYC + ZERO_SPACE_CYC / 4;
   localparam logic [31:0] c_os_lo = ONE_SPACE_CYC  - ONE_SPACE_CYC  / 4;
   localparam logic [31:0] c_os_hi = ONE_SPACE_CYC  + ONE_SPACE_CYC  / 4;

   // A space state must allow the longer of its two legal durations before timing out.
   localparam logic [31:0] c_ls_tmo = (c_ls_hi > c_rs_hi) ? c_ls_hi : c_rs_hi;
   localparam logic [31:0] c_bs_tmo = (c_os_hi > c_zs_hi) ? c_os_hi : c_zs_hi;

   localparam int c_hold_w = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;
   localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(HOLD_CYC);
   localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LEAD_MARK  = 3'd1,
      S_LEAD_SPACE = 3'd2,
      S_BIT_MARK   = 3'd3,
      S_BIT_SPACE  = 3'd4,
      S_CHECK      = 3'd5,
      S_RPT_MARK   = 3'd6
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [1:0]            r_sync;
   logic                  r_prev;
   logic [c_dur_w-1:0]    r_dur;
   logic [31:0]           r_shift;
   logic [4:0]            r_bit_cnt;
   logic [7:0]            r_button;
   logic [7:0]            r_addr;
   logic [c_hold_w-1:0]   r_hold;
   logic                  r_code_valid;
   logic                  r_repeat_valid;
   logic                  r_frame_err;
   logic                  r_busy;

   logic                  w_fall;
   logic                  w_rise;
   logic [31:0]           w_dur32;
   logic                  w_in_lm, w_in_ls, w_in_rs, w_in_bm, w_in_zs, w_in_os;
   logic                  w_cmd_ok;
   logic                  w_addr_ok;
   logic                  w_err;
   logic                  w_shift;
   logic                  w_shift_bit;
   logic                  w_bit_clr;
   logic                  w_code_ok;
   logic                  w_rpt_ok;

   // Line idles high, so the synchroniser resets to 1 to avoid a phantom fall.
   assign w_fall  = r_prev & ~r_sync[1];
   assign w_rise  = ~r_prev & r_sync[1];
   assign w_dur32 = {{(32-c_dur_w){1'b0}}, r_dur};

   assign w_in_lm = (w_dur32 >= c_lm_lo) && (w_dur32 <= c_lm_hi);
   assign w_in_ls = (w_dur32 >= c_ls_lo) && (w_dur32 <= c_ls_hi);
   assign w_in_rs = (w_dur32 >= c_rs_lo) && (w_dur32 <= c_rs_hi);
   assign w_in_bm = (w_dur32 >= c_bm_lo) && (w_dur32 <= c_bm_hi);
   assign w_in_zs = (w_dur32 >= c_zs_lo) && (w_dur32 <= c_zs_hi);
   assign w_in_os = (w_dur32 >= c_os_lo) && (w_dur32 <= c_os_hi);

   assign w_cmd_ok  = (r_shift[23:16] == ~r_shift[31:24]);
   assign w_addr_ok = !CHECK_ADDR || (r_shift[7:0] == ~r_shift[15:8]);

   always_ff @(posedge clk_50) begin
      if (reset) begin
         r_sync <= 2'b11;
         r_prev <= 1'b1;
         r_dur  <= '0;
      end else begin
         r_sync <= {r_sync[0], irda_rxd};
         r_prev <= r_sync[1];
         if (w_fall || w_rise)
            r_dur <= '0;
         else if (r_dur != c_dur_max)
            r_dur <= r_dur + c_dur_w'(1);
      end
   end

   always_ff @(posedge clk_50) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_err        = 1'b0;
      w_shift      = 1'b0;
      w_shift_bit  = 1'b0;
      w_bit_clr    = 1'b0;
      w_code_ok    = 1'b0;
      w_rpt_ok     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_fall)
               w_state_next = S_LEAD_MARK;
         end
         S_LEAD_MARK: begin
            if (w_rise) begin
               if (w_in_lm) w_state_next = S_LEAD_SPACE;
               else         w_err = 1'b1;
            end else if (w_dur32 > c_lm_hi) begin
               w_err = 1'b1;
            end
         end
         S_LEAD_SPACE: begin
            if (w_fall) begin
               if (w_in_ls) begin
                  w_state_next = S_BIT_MARK;
                  w_bit_clr    = 1'b1;
               end else if (w_in_rs) begin
                  w_state_next = S_RPT_MARK;
               end else begin
                  w_err = 1'b1;
               end
            end else if (w_dur32 > c_ls_tmo) begin
               w_err = 1'b1;
            end
         end
         S_BIT_MARK: begin
            if (w_rise) begin
               if (w_in_bm) w_state_next = S_BIT_SPACE;
               else         w_err = 1'b1;
            end else if (w_dur32 > c_bm_hi) begin
               w_err = 1'b1;
            end
         end
         S_BIT_SPACE: begin
            if (w_fall) begin
               if (w_in_zs || w_in_os) begin
                  w_shift      = 1'b1;
                  w_shift_bit  = w_in_os;
                  w_state_next = (r_bit_cnt == 5'd31) ? S_CHECK : S_BIT_MARK;
               end else begin
                  w_err = 1'b1;
               end
            end else if (w_dur32 > c_bs_tmo) begin
               w_err = 1'b1;
            end
         end
         S_CHECK: begin
            w_state_next = S_IDLE;
            if (w_cmd_ok && w_addr_ok) w_code_ok = 1'b1;
            else                       w_err = 1'b1;
         end
         S_RPT_MARK: begin
            if (w_rise) begin
               if (w_in_bm) begin
                  w_state_next = S_IDLE;
                  w_rpt_ok     = (r_button != IDLE_CODE);
               end else begin
                  w_err = 1'b1;
               end
            end else if (w_dur32 > c_bm_hi) begin
               w_err = 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
      if (w_err)
         w_state_next = S_IDLE;
   end

   always_ff @(posedge clk_50) begin
      if (reset) begin
         r_shift        <= '0;
         r_bit_cnt      <= '0;
         r_button       <= IDLE_CODE;
         r_addr         <= '0;
         r_hold         <= '0;
         r_code_valid   <= 1'b0;
         r_repeat_valid <= 1'b0;
         r_frame_err    <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_code_valid   <= w_code_ok;
         r_repeat_valid <= w_rpt_ok;
         r_frame_err    <= w_err;
         r_busy         <= (w_state_next != S_IDLE);

         // LSB-first: each new bit enters at the top and walks down to bit 0.
         if (w_shift)
            r_shift <= {w_shift_bit, r_shift[31:1]};

         if (w_bit_clr)
            r_bit_cnt <= '0;
         else if (w_shift)
            r_bit_cnt <= r_bit_cnt + 5'd1;

         // A reload in the same cycle as expiry keeps the key held.
         if (w_code_ok || w_rpt_ok) begin
            r_hold <= c_hold_load;
         end else if (r_hold != '0) begin
            r_hold <= r_hold - c_hold_one;
            if (r_hold == c_hold_one)
               r_button <= IDLE_CODE;
         end

         if (w_code_ok) begin
            r_button <= r_shift[23:16];
            r_addr   <= r_shift[7:0];
         end
      end
   end

   assign ir.ir_button    = r_button;
   assign ir.ir_addr      = r_addr;
   assign ir.code_valid   = r_code_valid;
   assign ir.repeat_valid = r_repeat_valid;
   assign ir.frame_err    = r_frame_err;
   assign ir.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_nec_ir_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_nec_ir_receiver                                              |
// | Brief    : Directed bench for nec_ir_receiver with timing scaled by 1/1000.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_nec_ir_receiver;

   localparam int LM   = 450;
   localparam int LS   = 225;
   localparam int RS   = 112;
   localparam int BM   = 28;
   localparam int ZS   = 28;
   localparam int OS   = 84;
   localparam int HOLD = 6000;
   localparam int RPT_PERIOD = 5400;

   logic clk_50   = 1'b0;
   logic reset    = 1'b1;
   logic irda_rxd = 1'b1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int n_code = 0, n_rpt = 0, n_err = 0;
   int code_cyc = 0, rpt_cyc = 0, stop_cyc = 0;
   logic err_line = 1'b1;

   nec_ir_receiver_if ir ();

   nec_ir_receiver #(
      .LEAD_MARK_CYC  (LM),
      .LEAD_SPACE_CYC (LS),
      .RPT_SPACE_CYC  (RS),
      .BIT_MARK_CYC   (BM),
      .ZERO_SPACE_CYC (ZS),
      .ONE_SPACE_CYC  (OS),
      .HOLD_CYC       (HOLD),
      .IDLE_CODE      (8'hFF),
      .CHECK_ADDR     (1'b0)
   ) dut (
      .clk_50   (clk_50),
      .reset    (reset),
      .irda_rxd (irda_rxd),
      .ir       (ir)
   );

   always #10 clk_50 = ~clk_50;

   always @(posedge clk_50) cyc <= cyc + 1;

   always @(negedge clk_50) begin
      if (ir.code_valid)   begin n_code++; code_cyc = cyc; end
      if (ir.repeat_valid) begin n_rpt++;  rpt_cyc  = cyc; end
      if (ir.frame_err)    begin n_err++;  err_line = irda_rxd; end
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic line(input logic v, input int n);
      irda_rxd = v;
      repeat (n) @(posedge clk_50);
      #1;
   endtask

   task automatic wait_pos(input int t);
      while (cyc < t) begin
         @(posedge clk_50);
         #1;
      end
   endtask

   task automatic wait_neg(input int t);
      while (cyc < t) @(negedge clk_50);
   endtask

   task automatic send_leader_bits(input logic [31:0] w, input int nbits);
      line(1'b0, LM);
      line(1'b1, LS);
      for (int i = 0; i < nbits; i++) begin
         line(1'b0, BM);
         line(1'b1, w[i] ? OS : ZS);
      end
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] an,
                             input logic [7:0] c, input logic [7:0] cn);
      send_leader_bits({cn, c, an, a}, 32);
      stop_cyc = cyc;
      line(1'b0, BM);
      line(1'b1, 200);
   endtask

   task automatic send_repeat();
      line(1'b0, LM);
      line(1'b1, RS);
      line(1'b0, BM);
      line(1'b1, 50);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (4) @(posedge clk_50);
      @(negedge clk_50);
      checks++; if (ir.ir_button !== 8'hFF) begin errors++; $display("FAIL reset_button: got %h expected ff", ir.ir_button); end
      checks++; if (ir.ir_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", ir.ir_addr); end
      checks++; if (ir.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", ir.busy); end
      checks++; if ({ir.code_valid, ir.repeat_valid, ir.frame_err} !== 3'b000) begin errors++;
         $display("FAIL reset_pulses: got %b expected 000", {ir.code_valid, ir.repeat_valid, ir.frame_err}); end
      @(posedge clk_50); #1;
      reset = 1'b0;
      line(1'b1, 20);
   endtask

   task automatic test_basic_frame();
      int c0, e0;
      c0 = n_code; e0 = n_err;
      send_frame(8'h00, 8'hFF, 8'h0F, 8'hF0);
      checks++; if (n_code - c0 !== 1) begin errors++; $display("FAIL basic_code_cnt: got %0d expected 1", n_code - c0); end
      checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL basic_err_cnt: got %0d expected 0", n_err - e0); end
      checks++; if (ir.ir_button !== 8'h0F) begin errors++; $display("FAIL basic_button: got %h expected 0f", ir.ir_button); end
      checks++; if (ir.ir_addr !== 8'h00) begin errors++; $display("FAIL basic_addr: got %h expected 00", ir.ir_addr); end
      checks++; if (code_cyc - stop_cyc !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", code_cyc - stop_cyc); end
      checks++; if (ir.busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", ir.busy); end
   endtask

   task automatic test_repeat_hold();
      int t0, c0, r0, hold_end;
      @(posedge clk_50); #1;
      t0 = cyc; c0 = n_code; r0 = n_rpt;
      send_frame(8'h00, 8'hFF, 8'h13, 8'hEC);
      for (int k = 1; k <= 3; k++) begin
         wait_pos(t0 + k * RPT_PERIOD);
         send_repeat();
      end
      checks++; if (n_code - c0 !== 1) begin errors++; $display("FAIL rpt_code_cnt: got %0d expected 1", n_code - c0); end
      checks++; if (n_rpt - r0 !== 3) begin errors++; $display("FAIL rpt_cnt: got %0d expected 3", n_rpt - r0); end
      checks++; if (ir.ir_button !== 8'h13) begin errors++; $display("FAIL rpt_button: got %h expected 13", ir.ir_button); end
      hold_end = rpt_cyc + HOLD;
      wait_neg(hold_end - 1);
      checks++; if (ir.ir_button !== 8'h13) begin errors++; $display("FAIL hold_before_expiry: got %h expected 13", ir.ir_button); end
      wait_neg(hold_end);
      checks++; if (ir.ir_button !== 8'hFF) begin errors++; $display("FAIL hold_expired: got %h expected ff", ir.ir_button); end
   endtask

   task automatic test_bad_inverse();
      int c0, e0;
      @(posedge clk_50); #1;
      c0 = n_code; e0 = n_err;
      send_frame(8'h00, 8'hFF, 8'h07, 8'hF0);
      checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL badinv_err_cnt: got %0d expected 1", n_err - e0); end
      checks++; if (n_code - c0 !== 0) begin errors++; $display("FAIL badinv_code_cnt: got %0d expected 0", n_code - c0); end
      checks++; if (ir.ir_button !== 8'hFF) begin errors++; $display("FAIL badinv_button: got %h expected ff", ir.ir_button); end
   endtask

   task automatic test_short_leader();
      int c0, e0;
      @(posedge clk_50); #1;
      e0 = n_err;
      line(1'b0, 300);
      line(1'b1, 100);
      checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL short_lead_err: got %0d expected 1", n_err - e0); end
      checks++; if (ir.busy !== 1'b0) begin errors++; $display("FAIL short_lead_busy: got %b expected 0", ir.busy); end
      c0 = n_code; e0 = n_err;
      send_frame(8'h21, 8'hDE, 8'h09, 8'hF6);
      checks++; if (n_code - c0 !== 1) begin errors++; $display("FAIL after_short_code: got %0d expected 1", n_code - c0); end
      checks++; if (ir.ir_button !== 8'h09) begin errors++; $display("FAIL after_short_button: got %h expected 09", ir.ir_button); end
      checks++; if (ir.ir_addr !== 8'h21) begin errors++; $display("FAIL after_short_addr: got %h expected 21", ir.ir_addr); end
      line(1'b1, HOLD + 50);
      checks++; if (ir.ir_button !== 8'hFF) begin errors++; $display("FAIL after_short_release: got %h expected ff", ir.ir_button); end
   endtask

   task automatic test_stuck_low();
      int c0, r0, e0;
      e0 = n_err;
      line(1'b0, 700);
      checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL stuck_err: got %0d expected 1", n_err - e0); end
      checks++; if (err_line !== 1'b0) begin errors++; $display("FAIL stuck_err_while_low: got %b expected 0", err_line); end
      line(1'b1, 200);
      checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL stuck_err_once: got %0d expected 1", n_err - e0); end
      c0 = n_code; r0 = n_rpt; e0 = n_err;
      send_repeat();
      checks++; if (n_rpt - r0 !== 0) begin errors++; $display("FAIL idle_rpt_pulse: got %0d expected 0", n_rpt - r0); end
      checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL idle_rpt_err: got %0d expected 0", n_err - e0); end
      checks++; if (n_code - c0 !== 0) begin errors++; $display("FAIL idle_rpt_code: got %0d expected 0", n_code - c0); end
   endtask

   task automatic test_reset_midframe();
      int c0, r0, e0;
      c0 = n_code; r0 = n_rpt; e0 = n_err;
      send_leader_bits({8'hFD, 8'h02, 8'hFF, 8'h00}, 15);
      line(1'b0, BM);
      line(1'b1, 10);
      reset = 1'b1;
      line(1'b1, 5);
      reset = 1'b0;
      @(negedge clk_50);
      checks++; if (ir.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", ir.busy); end
      checks++; if (ir.ir_addr !== 8'h00) begin errors++; $display("FAIL midreset_addr: got %h expected 00", ir.ir_addr); end
      @(posedge clk_50); #1;
      line(1'b1, 100);
      checks++; if ((n_code - c0) + (n_rpt - r0) + (n_err - e0) !== 0) begin errors++;
         $display("FAIL midreset_pulses: got %0d expected 0", (n_code - c0) + (n_rpt - r0) + (n_err - e0)); end
      send_frame(8'h00, 8'hFF, 8'h05, 8'hFA);
      checks++; if (n_code - c0 !== 1) begin errors++; $display("FAIL midreset_code_cnt: got %0d expected 1", n_code - c0); end
      checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL midreset_err_cnt: got %0d expected 0", n_err - e0); end
      checks++; if (ir.ir_button !== 8'h05) begin errors++; $display("FAIL midreset_button: got %h expected 05", ir.ir_button); end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_repeat_hold();
      test_bad_inverse();
      test_short_leader();
      test_stuck_low();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
